// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and width defaults for the pipeline hazard
//               controller and its optional performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int PC_W_DEF = 22;
  localparam int RA_W_DEF = 5;

  // Hazard controller sequencing states
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_cnt
// Description : Saturating event counters for stall and redirect cycles.
//               Built only when HAZARD_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_evt,
  input  logic        redirect_evt,
  output logic [31:0] stall_cycles,
  output logic [15:0] redirect_cnt
);

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;

  // Next-count: increment on event, hold at all-ones once saturated
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall_evt && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (redirect_evt && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall / flush / PC-redirect control for a 5-stage pipeline.
//               Memory stall beats branch redirect beats load-use. A branch
//               taken while a memory wait begins is held pending and replayed
//               once the access completes.
//               Optional: define HAZARD_PERF_CNT_EN to add stall/redirect
//               performance counter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] rs_ID,
  input  logic [RA_W-1:0] rt_ID,
  input  logic            use_rs_ID,
  input  logic            use_rt_ID,
  input  logic            mem_rd_EX,
  input  logic [RA_W-1:0] rd_EX,
  input  logic            branch_taken_EX,
  input  logic [PC_W-1:0] branch_tgt_EX,
  input  logic            dmem_req_MEM,
  input  logic            dmem_ack_MEM,
  output logic            stall_PC,
  output logic            stall_IF_ID,
  output logic            stall_ID_EX,
  output logic            stall_EX_MEM,
  output logic            flush_IF_ID,
  output logic            flush_ID_EX,
  output logic            pc_redirect,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PC_W-1:0] pc_redirect_tgt,
  output logic [31:0]     stall_cycles,
  output logic [15:0]     redirect_cnt
`else
  output logic [PC_W-1:0] pc_redirect_tgt
`endif
);

  hz_state_e       state_q, state_d;
  logic            pend_vld_q, pend_vld_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic            load_use;
  logic            mem_stall;
  logic            stall_all;
  logic            ld_stall;
  logic            redir;
  logic [PC_W-1:0] redir_tgt;

  // A load in EX feeding a source read in ID; r0 never creates a hazard
  assign load_use = mem_rd_EX && (rd_EX != '0) &&
                    ((use_rs_ID && (rs_ID == rd_EX)) ||
                     (use_rt_ID && (rt_ID == rd_EX)));

  assign mem_stall = dmem_req_MEM && !dmem_ack_MEM;

  // Next-state, pending-target capture and raw control outputs
  always_comb begin
    state_d    = state_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    stall_all  = 1'b0;
    ld_stall   = 1'b0;
    redir      = 1'b0;
    redir_tgt  = '0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          // Freeze everything; a coincident branch is remembered, not lost
          stall_all = 1'b1;
          state_d   = MEM_WAIT;
          if (branch_taken_EX) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = branch_tgt_EX;
          end
        end else if (branch_taken_EX) begin
          redir     = 1'b1;
          redir_tgt = branch_tgt_EX;
        end else if (load_use) begin
          ld_stall = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ack_MEM) begin
          stall_all = 1'b1;
        end else begin
          state_d = pend_vld_q ? REDIRECT : RUN;
        end
      end
      REDIRECT: begin
        redir      = 1'b1;
        redir_tgt  = pend_tgt_q;
        pend_vld_d = 1'b0;
        state_d    = RUN;
      end
      default: begin
        state_d    = RUN;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  // State and pending-branch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Outputs are forced low while reset is held, whatever the inputs do
  assign stall_PC        = rst_n & (stall_all | ld_stall);
  assign stall_IF_ID     = rst_n & (stall_all | ld_stall);
  assign stall_ID_EX     = rst_n & stall_all;
  assign stall_EX_MEM    = rst_n & stall_all;
  assign flush_IF_ID     = rst_n & redir;
  assign flush_ID_EX     = rst_n & (redir | ld_stall);
  assign pc_redirect     = rst_n & redir;
  assign pc_redirect_tgt = rst_n ? redir_tgt : '0;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_perf_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_evt    (stall_PC),
    .redirect_evt (pc_redirect),
    .stall_cycles (stall_cycles),
    .redirect_cnt (redirect_cnt)
  );
`endif

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed-vector self-checking bench for pipeline_hazard_ctrl.
//               Define HAZARD_PERF_CNT_EN to also check the counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int PC_W = 22;
  localparam int RA_W = 5;

  // Output bit order: stall_PC stall_IF_ID stall_ID_EX stall_EX_MEM
  //                   flush_IF_ID flush_ID_EX pc_redirect
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_LDUSE = 7'b1100010;
  localparam logic [6:0] O_REDIR = 7'b0000111;
  localparam logic [6:0] O_MSTL  = 7'b1111000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RA_W-1:0] rs_ID, rt_ID, rd_EX;
  logic            use_rs_ID, use_rt_ID, mem_rd_EX;
  logic            branch_taken_EX;
  logic [PC_W-1:0] branch_tgt_EX;
  logic            dmem_req_MEM, dmem_ack_MEM;
  logic            stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM;
  logic            flush_IF_ID, flush_ID_EX, pc_redirect;
  logic [PC_W-1:0] pc_redirect_tgt;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]     stall_cycles;
  logic [15:0]     redirect_cnt;
`endif
  logic [6:0]      outs;

  int n_vec     = 0;
  int n_miscmp  = 0;

  always #5 clk = ~clk;

  assign outs = {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
                 flush_IF_ID, flush_ID_EX, pc_redirect};

  pipeline_hazard_ctrl #(.PC_W(PC_W), .RA_W(RA_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs_ID           (rs_ID),
    .rt_ID           (rt_ID),
    .use_rs_ID       (use_rs_ID),
    .use_rt_ID       (use_rt_ID),
    .mem_rd_EX       (mem_rd_EX),
    .rd_EX           (rd_EX),
    .branch_taken_EX (branch_taken_EX),
    .branch_tgt_EX   (branch_tgt_EX),
    .dmem_req_MEM    (dmem_req_MEM),
    .dmem_ack_MEM    (dmem_ack_MEM),
    .stall_PC        (stall_PC),
    .stall_IF_ID     (stall_IF_ID),
    .stall_ID_EX     (stall_ID_EX),
    .stall_EX_MEM    (stall_EX_MEM),
    .flush_IF_ID     (flush_IF_ID),
    .flush_ID_EX     (flush_ID_EX),
    .pc_redirect     (pc_redirect),
`ifdef HAZARD_PERF_CNT_EN
    .pc_redirect_tgt (pc_redirect_tgt),
    .stall_cycles    (stall_cycles),
    .redirect_cnt    (redirect_cnt)
`else
    .pc_redirect_tgt (pc_redirect_tgt)
`endif
  );

  task automatic check_vec(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, compare both output word and target
  task automatic check_outs(input string tag, input logic [6:0] eo,
                            input logic [PC_W-1:0] et);
    #3;
    check_vec({tag, ".ctl"}, {25'd0, outs}, {25'd0, eo});
    check_vec({tag, ".tgt"}, {10'd0, pc_redirect_tgt}, {10'd0, et});
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_ID = '0; rt_ID = '0; rd_EX = '0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; mem_rd_EX = 1'b0;
    branch_taken_EX = 1'b0; branch_tgt_EX = '0;
    dmem_req_MEM = 1'b0; dmem_ack_MEM = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    // Reset dominates any input combination
    dmem_req_MEM = 1'b1; branch_taken_EX = 1'b1; branch_tgt_EX = 22'h00ABC;
    mem_rd_EX = 1'b1; rd_EX = 5'd3; rs_ID = 5'd3; use_rs_ID = 1'b1;
    check_outs("in_reset", O_NONE, '0);
    tick();
    idle(); rst_n = 1'b1;
    check_outs("post_reset", O_NONE, '0);
    tick();

    // Load-use on rs, then bubble gone
    mem_rd_EX = 1'b1; rd_EX = 5'd3; rs_ID = 5'd3; use_rs_ID = 1'b1;
    check_outs("lduse_rs", O_LDUSE, '0);
    tick(); idle();
    check_outs("lduse_after", O_NONE, '0);
    tick();
    // r0 destination is never a hazard
    mem_rd_EX = 1'b1; rd_EX = 5'd0; rs_ID = 5'd0; use_rs_ID = 1'b1;
    check_outs("lduse_r0", O_NONE, '0);
    tick(); idle();
    // Hazard through rt; same regs but not read -> none
    mem_rd_EX = 1'b1; rd_EX = 5'd7; rt_ID = 5'd7; use_rt_ID = 1'b1;
    check_outs("lduse_rt", O_LDUSE, '0);
    tick();
    use_rt_ID = 1'b0;
    check_outs("lduse_rt_unused", O_NONE, '0);
    tick(); idle();

    // Taken branch redirects for one cycle
    branch_taken_EX = 1'b1; branch_tgt_EX = 22'h00ABC;
    check_outs("branch", O_REDIR, 22'h00ABC);
    tick(); idle();
    check_outs("branch_after", O_NONE, '0);
    tick();

    // Req and ack together: no stall
    dmem_req_MEM = 1'b1; dmem_ack_MEM = 1'b1;
    check_outs("req_ack", O_NONE, '0);
    tick(); idle();

    // Memory wait: four stall cycles, release on ack
    dmem_req_MEM = 1'b1;
    check_outs("mwait_c1", O_MSTL, '0);
    tick();
    check_outs("mwait_c2", O_MSTL, '0);
    tick();
    branch_taken_EX = 1'b1; branch_tgt_EX = 22'h00155;
    mem_rd_EX = 1'b1; rd_EX = 5'd4; rs_ID = 5'd4; use_rs_ID = 1'b1;
    check_outs("mwait_ignore", O_MSTL, '0);
    tick(); idle(); dmem_req_MEM = 1'b1;
    check_outs("mwait_c4", O_MSTL, '0);
    tick();
    dmem_ack_MEM = 1'b1;
    check_outs("mwait_ack", O_NONE, '0);
    tick(); idle();
    // Back in RUN: a branch acts immediately
    branch_taken_EX = 1'b1; branch_tgt_EX = 22'h00155;
    check_outs("mwait_run", O_REDIR, 22'h00155);
    tick(); idle();

    // Deferred branch across a 3-cycle wait
    dmem_req_MEM = 1'b1; branch_taken_EX = 1'b1; branch_tgt_EX = 22'h12345;
    check_outs("defer_c1", O_MSTL, '0);
    tick(); idle(); dmem_req_MEM = 1'b1;
    check_outs("defer_c2", O_MSTL, '0);
    tick();
    check_outs("defer_c3", O_MSTL, '0);
    tick();
    dmem_ack_MEM = 1'b1;
    check_outs("defer_ack", O_NONE, '0);
    tick(); idle();
    check_outs("defer_redir", O_REDIR, 22'h12345);
    tick();
    check_outs("defer_after", O_NONE, '0);
    tick();

    // Priority: all three hazards at once -> only memory stall
    dmem_req_MEM = 1'b1;
    branch_taken_EX = 1'b1; branch_tgt_EX = 22'h3FFFFF;
    mem_rd_EX = 1'b1; rd_EX = 5'd31; rs_ID = 5'd31; use_rs_ID = 1'b1;
    check_outs("prio", O_MSTL, '0);
    tick(); idle(); dmem_req_MEM = 1'b1; dmem_ack_MEM = 1'b1;
    check_outs("prio_ack", O_NONE, '0);
    tick(); idle();
    check_outs("prio_pend", O_REDIR, 22'h3FFFFF);
    tick();
    check_outs("prio_after", O_NONE, '0);
    tick();

    // Reset during MEM_WAIT with a pending branch
    dmem_req_MEM = 1'b1; branch_taken_EX = 1'b1; branch_tgt_EX = 22'h2AAAA;
    check_outs("rstw_c1", O_MSTL, '0);
    tick(); idle(); dmem_req_MEM = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    check_vec("cnt_stall", stall_cycles, 32'd11);
    check_vec("cnt_redir", {16'd0, redirect_cnt}, 32'd4);
`endif
    dmem_ack_MEM = 1'b1;
    rst_n = 1'b0;
    check_outs("rstw_inrst", O_NONE, '0);
    tick();
    idle(); rst_n = 1'b1;
    check_outs("rstw_rel", O_NONE, '0);
    tick();
    check_outs("rstw_noredir", O_NONE, '0);
`ifdef HAZARD_PERF_CNT_EN
    check_vec("cnt_stall_rst", stall_cycles, 32'd0);
    check_vec("cnt_redir_rst", {16'd0, redirect_cnt}, 32'd0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
